// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, bit timing and the TX issue
// controller state encoding used by uart_tx_fifo.
package uart_pkg;

  localparam int BYTE_W       = 8;
  localparam int CLKS_PER_BIT = 87;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte-wide circular FIFO with occupancy count, registered full/empty flags
// and a one-cycle overflow pulse for a write dropped while full.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] pop_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Accept/reject decisions use the pre-edge flags, so a full FIFO drops a
  // write even when a pop happens on the same edge.
  always_comb begin
    push_ok_s  = 1'b0;
    pop_ok_s   = 1'b0;
    overflow_d = 1'b0;
    if (push_i && !full_q) begin
      push_ok_s = 1'b1;
    end else begin
      overflow_d = push_i;
    end
    if (pop_i && !empty_q) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
  end

  // Next pointers, count and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_MAX);
    empty_d = (count_d == CNT_ZERO);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !rst_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus issue controller feeding uart_tx: pops one byte, pulses
// o_TX_DV, waits for o_TX_Done, then enforces an inter-byte idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [BYTE_W-1:0] i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_TX_DV,
  output logic [BYTE_W-1:0] o_TX_Byte,
  input  logic              i_TX_Active,
  input  logic              i_TX_Done,
  output logic              o_Busy
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  tx_state_e         state_q;
  logic [7:0]        gap_q;
  logic              tx_dv_q;
  logic [BYTE_W-1:0] tx_byte_q;
  logic              busy_q;
  logic              pop_s;
  logic              fifo_empty_s;
  logic [BYTE_W-1:0] pop_data_s;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i       (i_Clock),
    .rst_i       (i_Reset),
    .push_i      (i_Wr_DV),
    .push_data_i (i_Wr_Byte),
    .pop_i       (pop_s),
    .pop_data_o  (pop_data_s),
    .count_o     (o_Count),
    .full_o      (o_Full),
    .empty_o     (fifo_empty_s),
    .overflow_o  (o_Overflow)
  );

  // A pop happens exactly on the IDLE->ISSUE transition.
  always_comb begin
    pop_s = 1'b0;
    if ((state_q == S_IDLE) && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Issue controller with registered DV, byte and busy outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      gap_q     <= 8'd0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty_s) begin
            state_q   <= S_ISSUE;
            tx_dv_q   <= 1'b1;
            tx_byte_q <= pop_data_s;
            busy_q    <= 1'b1;
          end else begin
            tx_dv_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT_DONE;
          tx_dv_q <= 1'b0;
        end
        S_WAIT_DONE: begin
          if (i_TX_Done) begin
            state_q <= S_GAP;
            gap_q   <= GAP_LOAD;
          end
        end
        S_GAP: begin
          // The gap only ends once uart_tx has also dropped its active flag.
          if (gap_q != 8'd0) begin
            gap_q <= gap_q - 8'd1;
          end else if (!i_TX_Active) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_dv_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = tx_byte_q;
  assign o_Busy    = busy_q;
  assign o_Empty   = fifo_empty_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo with a behavioural uart_tx stub.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int GAP    = 2;
  localparam int FRAME  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_dv = 1'b0;
  logic [7:0]  wr_byte = 8'h00;
  logic        tx_active;
  logic        tx_done;
  logic        o_Full, o_Empty, o_Overflow, o_TX_DV, o_Busy;
  logic [ADDR_W:0] o_Count;
  logic [7:0]  o_TX_Byte;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .o_Full(o_Full), .o_Empty(o_Empty), .o_Count(o_Count), .o_Overflow(o_Overflow),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .i_TX_Active(tx_active),
    .i_TX_Done(tx_done), .o_Busy(o_Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int  dv_cnt = 0;
  int  ovf_cnt = 0;
  int  last_done = 0;
  bit  done_valid = 1'b0;
  bit  gap_chk = 1'b0;
  bit  in_flight = 1'b0;
  bit  dv_prev = 1'b0;
  logic [7:0] held = 8'h00;
  bit  stub_auto = 1'b1;
  int  man_req = 0;
  int  man_ack = 0;
  int  frame_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit accepted);
    @(posedge clk); #1;
    wr_dv = 1'b1;
    wr_byte = b;
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic wr_end();
    @(posedge clk); #1;
    wr_dv = 1'b0;
  endtask

  task automatic wait_dv(input int limit, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (o_TX_DV) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_dv: no o_TX_DV within %0d cycles", limit);
    end
  endtask

  task automatic wait_idle(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!o_Busy && o_Empty && frame_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: controller still busy after %0d cycles", limit);
    end
  endtask

  // uart_tx stub: auto mode answers each DV with done FRAME cycles later;
  // man_req bumps request a single done pulse regardless of state.
  initial begin
    tx_active = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (man_req != man_ack) begin
        tx_done = 1'b1;
        man_ack++;
      end else if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) begin
          tx_done = 1'b1;
          tx_active = 1'b0;
        end
      end else if (o_TX_DV && stub_auto) begin
        tx_active = 1'b1;
        frame_cnt = FRAME;
      end
    end
  end

  // Monitor: pops the scoreboard on every DV and checks pulse width, byte
  // stability until done, and the done-to-DV spacing during bursts.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_flight = 1'b0;
        dv_prev = 1'b0;
      end else begin
        if (!gap_chk) done_valid = 1'b0;
        if (o_Overflow) ovf_cnt++;
        if (dv_prev) chk("dv_width", 32'(o_TX_DV), 32'd0);
        if (tx_done && in_flight) begin
          chk("byte_hold", 32'(o_TX_Byte), 32'(held));
          in_flight = 1'b0;
          last_done = cyc;
          done_valid = 1'b1;
        end
        if (o_TX_DV) begin
          dv_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_dv: got byte %02h, none expected", o_TX_Byte);
          end else begin
            chk("tx_byte", 32'(o_TX_Byte), 32'(exp_q.pop_front()));
          end
          if (gap_chk && done_valid) chk("done_to_dv", 32'(cyc - last_done), 32'(GAP + 2));
          held = o_TX_Byte;
          in_flight = 1'b1;
        end
        dv_prev = o_TX_DV;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcyc;
    int dvc;
    int ovf_base;
    int sent;
    int guard;

    // Reset state
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", 32'(o_Empty), 32'd1);
    chk("rst_full", 32'(o_Full), 32'd0);
    chk("rst_count", 32'(o_Count), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_dv", 32'(o_TX_DV), 32'd0);
    chk("rst_byte", 32'(o_TX_Byte), 32'h00);
    chk("rst_ovf", 32'(o_Overflow), 32'd0);

    // Single byte: DV two cycles after the write cycle, FIFO empty after pop
    wr(8'h3F, 1'b1);
    wcyc = cyc;
    wr_end();
    wait_dv(10, dvc);
    chk("single_latency", 32'(dvc - wcyc), 32'd2);
    chk("single_empty", 32'(o_Empty), 32'd1);
    chk("single_count", 32'(o_Count), 32'd0);
    chk("single_busy", 32'(o_Busy), 32'd1);
    wait_idle(FRAME + 20);

    // Burst of five; first byte leaves after one clock so count peaks at 4
    gap_chk = 1'b1;
    for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
    wr_end();
    @(negedge clk);
    chk("burst_count_peak", 32'(o_Count), 32'd4);
    wait_idle(5 * (FRAME + 10));
    gap_chk = 1'b0;

    // Full/overflow with done withheld: A0 in flight, A1..B0 fill all 16, B1 drops
    stub_auto = 1'b0;
    ovf_base = ovf_cnt;
    for (int i = 0; i < 18; i++) wr(8'hA0 + 8'(i), (i < 17));
    wr_end();
    @(negedge clk);
    chk("full_ovf_pulse", 32'(o_Overflow), 32'd1);
    chk("full_count", 32'(o_Count), 32'd16);
    chk("full_flag", 32'(o_Full), 32'd1);
    @(negedge clk);
    chk("full_ovf_clear", 32'(o_Overflow), 32'd0);
    // release A0; a write on the pop edge is still dropped on the pre-edge full
    man_req++;
    @(posedge clk); #1;
    stub_auto = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    wr_dv = 1'b1;
    wr_byte = 8'hC0;
    @(posedge clk); #1;
    wr_dv = 1'b0;
    @(negedge clk);
    chk("pop_edge_ovf", 32'(o_Overflow), 32'd1);
    chk("pop_edge_count", 32'(o_Count), 32'd15);
    chk("pop_edge_full", 32'(o_Full), 32'd0);
    wait_idle(17 * (FRAME + 10));
    chk("ovf_pulses", 32'(ovf_cnt - ovf_base), 32'd2);

    // Wrap-around: 40 bytes throttled on o_Full
    ovf_base = ovf_cnt;
    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
      if (!o_Full) begin
        wr_dv = 1'b1;
        wr_byte = 8'(sent);
        exp_q.push_back(8'(sent));
        sent++;
      end else begin
        wr_dv = 1'b0;
      end
    end
    wr_end();
    chk("wrap_all_written", 32'(sent), 32'd40);
    wait_idle(40 * (FRAME + 10));
    chk("wrap_no_ovf", 32'(ovf_cnt - ovf_base), 32'd0);

    // Simultaneous push and pop with count=1 in IDLE
    wr(8'h11, 1'b1);
    wr(8'h55, 1'b1);
    wr_end();
    @(negedge clk);
    chk("pushpop_count", 32'(o_Count), 32'd1);
    wait_idle(2 * (FRAME + 10));

    // Reset while WAIT_DONE with three bytes queued
    stub_auto = 1'b0;
    wr(8'h61, 1'b1);
    wr(8'h62, 1'b0);
    wr(8'h63, 1'b0);
    wr(8'h64, 1'b0);
    wr_end();
    repeat (3) @(negedge clk);
    chk("pre_reset_count", 32'(o_Count), 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_empty", 32'(o_Empty), 32'd1);
    chk("midrst_busy", 32'(o_Busy), 32'd0);
    chk("midrst_dv", 32'(o_TX_DV), 32'd0);
    chk("midrst_count", 32'(o_Count), 32'd0);
    chk("midrst_byte", 32'(o_TX_Byte), 32'h00);
    man_req++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stray_done_dv", 32'(o_TX_DV), 32'd0);
    end
    stub_auto = 1'b1;
    dvc = dv_cnt;
    wr(8'hC3, 1'b1);
    wr_end();
    wait_idle(FRAME + 20);
    chk("post_reset_dv_count", 32'(dv_cnt - dvc), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
